imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
// - Boot-time program loader directly upstream of instruction_memory in the monocycle core.
// - Receives a byte stream over valid/ready and assembles little-endian 32-bit words.
// - Writes each word into the instruction memory write port.
// - Holds the core in reset until the whole image is written, then releases it.
// PARAMETERS
// - BASE_ADDR    32'h0000_0000  byte address of the first word written
// - DEPTH_WORDS  256            instruction memory capacity in words; larger images are rejected
// PORTS
// - clk          in   1   system clock; every flop on rising edge
// - reset        in   1   synchronous, active-low reset
// - in_valid     in   1   in_byte valid
// - in_ready     out  1   loader can accept a byte
// - in_byte      in   8   stream byte
// - restart      in   1   1-cycle pulse: reload (honoured only in DONE/ERROR)
// - mem_we       out  1   instruction memory write strobe, 1-cycle pulse
// - mem_addr     out  32  write byte address = BASE_ADDR + 4*word_index
// - mem_wdata    out  32  write data
// - core_hold    out  1   1 = keep monociclo in reset
// - done         out  1   image loaded, core released
// - error        out  1   load aborted
// - word_count   out  16  words written so far
// BEHAVIOUR
// - Transfer happens when in_valid && in_ready. Source holds in_byte stable while in_valid && !in_ready.
// - Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), 4*N payload bytes, then
//   optional checksum byte (see CONFIGURATION).
// - Reset (reset==0 at edge) returns all state and outputs to reset values:
//   - state=LEN_LO, in_ready=1, core_hold=1
//   - mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0
//   - done=0, error=0, word_count=0, byte index=0
//   - memory contents are not cleared
// - FSM: LEN_LO -> LEN_HI -> DATA <-> WRITE -> [CHECK] -> DONE, plus ERROR.
//   - LEN_LO: accept byte into len[7:0].
//   - LEN_HI: accept byte into len[15:8], then:
//     - len==0: go to CHECK if enabled, else DONE.
//     - len>DEPTH_WORDS: go to ERROR.
//     - otherwise: go to DATA.
//   - DATA: byte k (k=0..3) goes to word[8k+7:8k]. On the 4th byte go to WRITE.
//   - WRITE: exactly one cycle.
//     - mem_we=1, mem_addr=BASE_ADDR+4*word_count, mem_wdata=word, in_ready=0.
//     - word_count increments at the end of the cycle.
//     - Next: DATA if more words remain, else CHECK or DONE.
//   - DONE: core_hold=0, done=1, in_ready=0.
//   - ERROR: core_hold=1, error=1, in_ready=0. No further mem_we.
//   - restart in DONE/ERROR: go to LEN_LO, clear word_count, done and error, set core_hold=1.
//     restart in any other state is ignored.
// - Latency: mem_we is asserted the cycle after the 4th-byte handshake. With in_valid held
//   high, one word takes 5 cycles.
// - Idle gaps (in_valid=0) are allowed anywhere and do not change state. No timeout.
// - mem_addr arithmetic is 32-bit. word_count never exceeds DEPTH_WORDS, so no wrap.
// - A partial word at reset or restart is discarded.
// - Outputs are registered. core_hold only deasserts in DONE.
// CONFIGURATION
// - LOADER_CHECKSUM_EN defined:
//   - Running 8-bit sum (mod 256) of all payload bytes, cleared in LEN_LO.
//   - After the last word (or when len==0), state CHECK accepts one byte.
//   - Byte equals sum: go to DONE. Otherwise: go to ERROR.
// - LOADER_CHECKSUM_EN undefined:
//   - No CHECK state and no sum register.
//   - The last WRITE (or len==0) goes directly to DONE.
//   - The only error source is len>DEPTH_WORDS.
// TESTING
// - Bytes 02 00 13 05 A0 00 93 05 B0 00, in_valid held high -> mem_we at addr 0 data 00A00513,
//   then addr 4 data 00B00593; done=1, core_hold=0, word_count=2.
// - Header 00 00 -> DONE after 2 handshakes, no mem_we pulse (checksum build: send 00 first).
// - DEPTH_WORDS=256, header 01 01 (257) -> error=1, core_hold=1, in_ready=0, no mem_we;
//   restart -> LEN_LO, in_ready=1.
// - Same 2-word image with random in_valid gaps -> identical writes. in_ready=0 only in WRITE
//   cycles. No byte lost or duplicated.
// - reset low after 6 payload bytes -> all outputs at reset values. Reloading from LEN_LO writes
//   from BASE_ADDR with no leftover bytes.
// - LOADER_CHECKSUM_EN, 1-word image 13 05 A0 00:
//   - checksum byte B8 -> DONE.
//   - checksum byte B9 -> ERROR, core_hold stays 1.

Source files
------------

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream valid/ready channel into the loader.
// Ports: in_valid/in_byte from source (master), in_ready from loader (slave).
interface imem_loader_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;

  modport master (
    output in_valid,
    output in_byte,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_byte,
    output in_ready
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot loader, byte stream -> LE words -> imem write port.
// Holds the core in reset until the whole image has been written.
// Ports: clk, reset (sync, active-low), s (byte stream slave), restart,
//   mem_we/mem_addr/mem_wdata (imem write), core_hold, done, error,
//   word_count (words written).
// Option: LOADER_CHECKSUM_EN adds a trailing mod-256 payload checksum byte.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic               clk,
  input  logic               reset,
  imem_loader_if.slave       s,
  input  logic               restart,
  output logic               mem_we,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_wdata,
  output logic               core_hold,
  output logic               done,
  output logic               error,
  output logic [15:0]        word_count
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE,
    S_CHECK, S_DONE, S_ERROR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE,
    S_DONE, S_ERROR
  } state_t;
`endif

  localparam logic [16:0] LP_DEPTH = 17'(DEPTH_WORDS);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_len;
  logic [31:0] r_word;
  logic [1:0]  r_idx;
  logic [15:0] r_count;
  logic        w_fire;
  logic [15:0] w_len;
  logic        w_last;
  logic        w_ready;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  r_sum;
`endif

  assign w_fire = s.in_valid && w_ready;
  assign w_len  = {s.in_byte, r_len[7:0]};
  assign w_last = (r_count + 16'd1) == r_len;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_LEN_LO;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_LEN_LO: if (w_fire) w_next = S_LEN_HI;
      S_LEN_HI: begin
        if (w_fire) begin
          if (w_len == 16'd0)
`ifdef LOADER_CHECKSUM_EN
            w_next = S_CHECK;
`else
            w_next = S_DONE;
`endif
          else if ({1'b0, w_len} > LP_DEPTH)
            w_next = S_ERROR;
          else
            w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_fire && r_idx == 2'd3)
          w_next = S_WRITE;
      end
      S_WRITE: begin
        if (!w_last)
          w_next = S_DATA;
        else
`ifdef LOADER_CHECKSUM_EN
          w_next = S_CHECK;
`else
          w_next = S_DONE;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (w_fire)
          w_next = (s.in_byte == r_sum) ? S_DONE : S_ERROR;
      end
`endif
      S_DONE:  if (restart) w_next = S_LEN_LO;
      S_ERROR: if (restart) w_next = S_LEN_LO;
      default: w_next = S_LEN_LO;
    endcase
  end

  // Datapath: length, word assembly, count, checksum
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_len   <= '0;
      r_word  <= '0;
      r_idx   <= '0;
      r_count <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      unique case (r_state)
        S_LEN_LO: begin
          r_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
          r_sum <= '0;
`endif
          if (w_fire) r_len[7:0] <= s.in_byte;
        end
        S_LEN_HI: begin
          if (w_fire) r_len[15:8] <= s.in_byte;
        end
        S_DATA: begin
          if (w_fire) begin
            r_word[{r_idx, 3'b000} +: 8] <= s.in_byte;
            r_idx <= r_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            r_sum <= r_sum + s.in_byte;
`endif
          end
        end
        S_WRITE: r_count <= r_count + 16'd1;
        S_DONE, S_ERROR: begin
          if (restart) begin
            r_count <= '0;
            r_idx   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state and datapath
  always_comb begin
    w_ready    = 1'b0;
    mem_we     = 1'b0;
    core_hold  = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    mem_addr   = BASE_ADDR + {14'd0, r_count, 2'b00};
    mem_wdata  = r_word;
    word_count = r_count;
    unique case (r_state)
      S_LEN_LO, S_LEN_HI, S_DATA: w_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: w_ready = 1'b1;
`endif
      S_WRITE: mem_we = 1'b1;
      S_DONE: begin
        core_hold = 1'b0;
        done      = 1'b1;
      end
      S_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  assign s.in_ready = w_ready;

endmodule
